// File: rtl/serial_rx_if.sv
// serial_rx_if: signal bundle between the UART receiver and its consumer.
//   rx_in     : serial line into the receiver (idle high)
//   rx_data   : last good byte received
//   rx_valid  : one-clock strobe, rx_data updated this cycle
//   frame_err : one-clock strobe, stop bit sampled low and byte discarded
//   busy      : receiver is inside a frame
// master = receiver side, slave = line driver / byte consumer side.
interface serial_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx_in,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/serial_rx.sv
// serial_rx: UART receiver, 8N1, LSB first, idle-high line.
// Samples the asynchronous line through a 2-flop synchronizer, centres on each bit
// and presents good bytes with a one-clock rx_valid strobe. A low stop bit gives a
// single frame_err strobe, then the receiver waits for the line to return high.
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   rx_if  : serial_rx_if.master (rx_in in; rx_data, rx_valid, frame_err, busy out)
// Parameters:
//   BitCnt  : clocks per bit (16..65535)
//   HalfCnt : clocks from start-edge detect to start-bit mid-sample
module serial_rx #(
    parameter int unsigned BitCnt  = 5625,
    parameter int unsigned HalfCnt = BitCnt / 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    serial_rx_if.master  rx_if
);
    localparam logic [15:0] BitLast  = 16'(BitCnt - 1);
    localparam logic [15:0] HalfLast = 16'(HalfCnt - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rxs_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_if.rx_in;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            bit_q       <= 3'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (!rxs_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Re-check the line at mid start bit; a short low pulse is a glitch.
                if (cnt_q == HalfLast) begin
                    cnt_d = 16'd0;
                    if (!rxs_q) begin
                        state_d = StData;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = 16'd0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = 16'd0;
                    if (rxs_q) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Held-low line: stay here so only one frame_err is reported.
                cnt_d = 16'd0;
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 16'd0;
            end
        endcase
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed and randomized frames against a behavioural line model.
module tb_serial_rx;
    localparam int unsigned B   = 50;
    localparam int unsigned H   = B / 2;
    localparam int unsigned LAT = 2 + H + 9 * B;
    localparam int unsigned TOL = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_rx_if bus ();

    serial_rx #(
        .BitCnt  (B),
        .HalfCnt (H)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .rx_if  (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes.
    logic [7:0]  vq_data[$];
    int unsigned vq_cyc[$];
    int          err_cnt   = 0;
    bit          busy_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_seen = 1'b1;
        if (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1)
            check("excl", {31'b0, bus.rx_valid & bus.frame_err}, 32'd0);
        if (bus.rx_valid === 1'b1) begin
            vq_data.push_back(bus.rx_data);
            vq_cyc.push_back(cyc);
        end
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        vq_data.delete();
        vq_cyc.delete();
        err_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    // Drives one frame starting at the current negedge; line is left at the stop value.
    task automatic send_frame(input logic [7:0] d, input int per, input logic stop,
                              input bit glitch, output int unsigned fall);
        fall = cyc;
        bus.rx_in = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                // Brief wrong level right at the bit edge, far from the sample point.
                bus.rx_in = ~d[i];
                tick(3);
                bus.rx_in = d[i];
                tick(per - 3);
            end else begin
                bus.rx_in = d[i];
                tick(per);
            end
        end
        bus.rx_in = stop;
        tick(per);
    endtask

    task automatic expect_good(input string tag, input logic [7:0] d, input int unsigned fall,
                               input bit chk_lat);
        int unsigned lat;
        check({tag, "_nvalid"}, vq_data.size(), 32'd1);
        check({tag, "_nerr"}, err_cnt, 32'd0);
        if (vq_data.size() >= 1) begin
            check({tag, "_data"}, {24'b0, vq_data[0]}, {24'b0, d});
            if (chk_lat) begin
                lat = vq_cyc[0] - fall;
                check({tag, "_lat_ok"}, {31'b0, (lat + TOL >= LAT) && (lat <= LAT + TOL)},
                      32'd1);
            end
        end
        clear_mon();
    endtask

    initial begin
        int unsigned fall;
        logic [7:0]  last_good;
        logic [7:0]  d;
        int          per;
        logic        stop;

        bus.rx_in = 1'b1;
        rst_n     = 1'b0;
        tick(3);

        // Reset state
        check("rst_data", {24'b0, bus.rx_data}, 32'h00);
        check("rst_valid", {31'b0, bus.rx_valid}, 32'd0);
        check("rst_err", {31'b0, bus.frame_err}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        clear_mon();
        tick(3000);
        check("idle_nvalid", vq_data.size(), 32'd0);
        check("idle_nerr", err_cnt, 32'd0);
        check("idle_busy_seen", {31'b0, busy_seen}, 32'd0);

        // Nominal frame with latency
        clear_mon();
        send_frame(8'hA5, B, 1'b1, 1'b0, fall);
        tick(B);
        check("a5_busy_after", {31'b0, bus.busy}, 32'd0);
        check("a5_port", {24'b0, bus.rx_data}, 32'hA5);
        expect_good("a5", 8'hA5, fall, 1'b1);
        last_good = 8'hA5;

        // Short low glitch rejected
        bus.rx_in = 1'b0;
        tick(H / 2);
        bus.rx_in = 1'b1;
        tick(2 * B);
        check("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
        check("glitch_nvalid", vq_data.size(), 32'd0);
        check("glitch_nerr", err_cnt, 32'd0);
        check("glitch_busy", {31'b0, bus.busy}, 32'd0);
        clear_mon();

        // Bad stop bit then held-low line
        send_frame(8'h3C, B, 1'b0, 1'b0, fall);
        tick(8 * B);
        check("brk_nerr", err_cnt, 32'd1);
        check("brk_nvalid", vq_data.size(), 32'd0);
        check("brk_data", {24'b0, bus.rx_data}, {24'b0, last_good});
        check("brk_busy_low", {31'b0, bus.busy}, 32'd1);
        bus.rx_in = 1'b1;
        tick(6);
        check("brk_busy_exit", {31'b0, bus.busy}, 32'd0);
        clear_mon();
        send_frame(8'h81, B, 1'b1, 1'b0, fall);
        expect_good("x81", 8'h81, fall, 1'b1);
        tick(B);

        // Back-to-back at -2% then +2%
        send_frame(8'h00, B - 1, 1'b1, 1'b0, fall);
        send_frame(8'hFF, B + 1, 1'b1, 1'b0, fall);
        check("b2b_nvalid", vq_data.size(), 32'd2);
        if (vq_data.size() == 2) begin
            check("b2b_first", {24'b0, vq_data[0]}, 32'h00);
            check("b2b_second", {24'b0, vq_data[1]}, 32'hFF);
        end
        clear_mon();
        last_good = 8'hFF;
        tick(B);

        // Reset during data bit 4 of 0x55
        d = 8'h55;
        bus.rx_in = 1'b0;
        tick(B);
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = d[i];
            tick(B);
        end
        bus.rx_in = d[4];
        tick(20);
        check("mid_busy", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        tick(3);
        check("mrst_data", {24'b0, bus.rx_data}, 32'h00);
        check("mrst_busy", {31'b0, bus.busy}, 32'd0);
        check("mrst_valid", {31'b0, bus.rx_valid}, 32'd0);
        bus.rx_in = 1'b1;
        rst_n     = 1'b1;
        tick(2 * B);
        check("mrst_nvalid", vq_data.size(), 32'd0);
        check("mrst_nerr", err_cnt, 32'd0);
        clear_mon();
        send_frame(8'h55, B, 1'b1, 1'b0, fall);
        expect_good("x55", 8'h55, fall, 1'b1);
        send_frame(8'h3C, B, 1'b1, 1'b0, fall);
        expect_good("loop3c", 8'h3C, fall, 1'b1);
        last_good = 8'h3C;
        tick(B);

        // Randomized frames: period jitter, bad stop bits, edge glitches
        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            per  = B - 1 + int'($urandom_range(0, 2));
            stop = ($urandom_range(0, 3) != 0);
            clear_mon();
            send_frame(d, per, stop, ($urandom_range(0, 1) == 1), fall);
            if (stop) begin
                expect_good($sformatf("rnd%0d", n), d, fall, per == int'(B));
                last_good = d;
                tick(int'($urandom_range(0, B)));
            end else begin
                check($sformatf("rnd%0d_nerr", n), err_cnt, 32'd1);
                check($sformatf("rnd%0d_nvalid", n), vq_data.size(), 32'd0);
                check($sformatf("rnd%0d_keep", n), {24'b0, bus.rx_data}, {24'b0, last_good});
                clear_mon();
                bus.rx_in = 1'b1;
                tick(int'($urandom_range(5, B)));
            end
        end
        check("final_data", {24'b0, bus.rx_data}, {24'b0, last_good});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
